// File: rtl/aes_enc_pkg.sv
// rtl/aes_enc_pkg.sv - AES forward-cipher types, S-box table and round helper functions
package aes_enc_pkg;

    typedef logic [0:7]   byte_t;
    typedef logic [0:127] block_t;

    // Controller states: waiting for plaintext, iterating rounds, holding ciphertext
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    // Forward S-box, entry n occupies bits [8n +: 8] (entry 0 is the leftmost byte)
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t sbox(byte_t b);
        return SBOX[8 * int'(b) +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic byte_t xtime(byte_t b);
        return {b[1:7], 1'b0} ^ (b[0] ? 8'h1B : 8'h00);
    endfunction

    function automatic block_t sub_bytes(block_t s);
        block_t r;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = sbox(s[8*k +: 8]);
        end
        return r;
    endfunction

    // Row r of the output takes column (c+r) mod 4 of the input; byte index is 4c+r
    function automatic block_t shift_rows(block_t s);
        block_t r;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[8*(4*c + row) +: 8] = s[8*(4*((c + row) % 4) + row) +: 8];
            end
        end
        return r;
    endfunction

    // Each column multiplied by the circulant {02 03 01 01}; 03*a is written xtime(a)^a
    function automatic block_t mix_columns(block_t s);
        block_t r;
        byte_t  a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c + 8 +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            r[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// rtl/aes_enc_round.sv - one combinational AES encryption round
module aes_enc_round
    import aes_enc_pkg::*;
(
    input  block_t s_i,
    input  block_t rk_i,
    input  logic   last_i,
    output block_t s_o
);

    block_t shifted;
    block_t mixed;

    assign shifted = shift_rows(sub_bytes(s_i));
    assign mixed   = mix_columns(shifted);

    // The final round bypasses MixColumns before the key addition
    assign s_o = (last_i ? shifted : mixed) ^ rk_i;

endmodule

// File: rtl/aes_enc_iter.sv
// rtl/aes_enc_iter.sv - iterative AES encryption core, one round per clock
module aes_enc_iter
    import aes_enc_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [3:0]   rk_idx,
    input  logic [0:127] rk,
    output logic [0:127] dout,
    output logic         dout_valid,
    input  logic         dout_ready
);

    localparam logic [3:0] NR_L = 4'(NR);

    fsm_e        fsm_q;
    logic [3:0]  rnd_q;
    block_t      state_q;
    block_t      dout_q;
    logic        dout_valid_q;
    block_t      round_d;
    logic        last_rnd;

    assign last_rnd = (rnd_q == NR_L);

    aes_enc_round u_round (
        .s_i    (state_q),
        .rk_i   (rk),
        .last_i (last_rnd),
        .s_o    (round_d)
    );

    // Key store is addressed by the current round only while iterating; load uses key 0
    assign rk_idx = (fsm_q == S_RUN) ? rnd_q : 4'd0;

    // A new block may enter when idle, or in the same cycle the finished block is taken
    assign din_ready = (fsm_q == S_IDLE) || ((fsm_q == S_DONE) && dout_ready);

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

    // Controller: loads the whitened block, iterates rounds, holds the result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q        <= S_IDLE;
            rnd_q        <= 4'd0;
            state_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (din_valid) begin
                        state_q <= din ^ rk;
                        rnd_q   <= 4'd1;
                        fsm_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    state_q <= round_d;
                    if (last_rnd) begin
                        dout_q       <= round_d;
                        dout_valid_q <= 1'b1;
                        fsm_q        <= S_DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (dout_ready) begin
                        dout_valid_q <= 1'b0;
                        if (din_valid) begin
                            state_q <= din ^ rk;
                            rnd_q   <= 4'd1;
                            fsm_q   <= S_RUN;
                        end else begin
                            fsm_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_iter.sv
// tb/tb_aes_enc_iter.sv - self-checking bench for aes_enc_iter against a GF(2^8) reference model
module tb_aes_enc_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [0:127] din = '0;
    logic         din_valid = 1'b0;
    logic         dout_ready = 1'b0;
    int           sel = 0;

    logic         dr10, dv10, dr14, dv14;
    logic [3:0]   ri10, ri14;
    logic [0:127] dout10, dout14, rk_in10, rk_in14;
    logic [0:127] rk10 [0:15];
    logic [0:127] rk14 [0:15];

    logic         o_valid, o_ready;
    logic [3:0]   o_rk_idx;
    logic [0:127] o_dout;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_m [0:255];
    logic [0:127] exp_rk [0:14];
    int           rkseq [$];

    assign rk_in10 = rk10[ri10];
    assign rk_in14 = rk14[ri14];

    assign o_valid  = (sel == 0) ? dv10   : dv14;
    assign o_ready  = (sel == 0) ? dr10   : dr14;
    assign o_rk_idx = (sel == 0) ? ri10   : ri14;
    assign o_dout   = (sel == 0) ? dout10 : dout14;

    aes_enc_iter #(.NR(10)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid && (sel == 0)),
        .din_ready  (dr10),
        .rk_idx     (ri10),
        .rk         (rk_in10),
        .dout       (dout10),
        .dout_valid (dv10),
        .dout_ready (dout_ready && (sel == 0))
    );

    aes_enc_iter #(.NR(14)) u_dut14 (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid && (sel == 1)),
        .din_ready  (dr14),
        .rk_idx     (ri14),
        .rk         (rk_in14),
        .dout       (dout14),
        .dout_valid (dv14),
        .dout_ready (dout_ready && (sel == 1))
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // key is left-justified: a 128-bit key sits in key[0:127]
    task automatic expand_key(input logic [0:255] key, input int nk, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int j = 0; j <= nr; j++) exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    function automatic logic [0:127] model_encrypt(input logic [0:127] pt, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   a [4];
        logic [0:127] k;
        logic [0:127] res;
        k = exp_rk[0];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[8*(4*c+r) +: 8] ^ k[8*(4*c+r) +: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = sbox_m[s[r][(c + r) % 4]];
            s = t;
            if (rd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[r][c];
                    for (int r = 0; r < 4; r++)
                        t[r][c] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
                s = t;
            end
            k = exp_rk[rd];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = s[r][c] ^ k[8*(4*c+r) +: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[8*(4*c+r) +: 8] = s[r][c];
        return res;
    endfunction

    task automatic load_store(input int which, input int nr);
        for (int j = 0; j <= nr; j++) begin
            if (which == 0) rk10[j] = exp_rk[j];
            else            rk14[j] = exp_rk[j];
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offers one block while idle, waits for the result, optionally completes the handshake
    task automatic run_block(input logic [0:127] pt, input logic [0:127] exp, input int nr,
                             input string tag, input bit do_hs);
        int n;
        check({tag, "_din_ready"}, 128'(o_ready), 128'(1));
        din       = pt;
        din_valid = 1'b1;
        rkseq.delete();
        rkseq.push_back(int'(o_rk_idx));
        @(posedge clk); #1;
        din_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 40) begin
            rkseq.push_back(int'(o_rk_idx));
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(nr));
        check({tag, "_dout"}, o_dout, exp);
        check({tag, "_rkseq_len"}, 128'(rkseq.size()), 128'(nr + 1));
        for (int i = 0; i < rkseq.size() && i <= nr; i++)
            check({tag, "_rk_idx"}, 128'(rkseq[i]), 128'(i));
        if (do_hs) begin
            dout_ready = 1'b1;
            @(posedge clk); #1;
            dout_ready = 1'b0;
            check({tag, "_valid_drop"}, 128'(o_valid), 128'(0));
        end
    endtask

    localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:255] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        logic [0:127] pa, pb, ca, cb, ck, pr;
        logic [0:255] kr;
        int n;

        for (int j = 0; j < 16; j++) begin
            rk10[j] = '0;
            rk14[j] = '0;
        end
        build_sbox();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", o_dout, 128'h0);
        check("reset_valid", 128'(o_valid), 128'(0));
        check("reset_din_ready", 128'(o_ready), 128'(1));
        check("reset_rk_idx", 128'(o_rk_idx), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // 1. FIPS-197 App.B
        expand_key({KEY_B, 128'h0}, 4, 10);
        check("model_appB", model_encrypt(PT_B, 10), CT_B);
        load_store(0, 10);
        run_block(PT_B, CT_B, 10, "appB", 1'b1);

        // 2. FIPS-197 App.C.1 with round-key index trace
        expand_key({KEY_C1, 128'h0}, 4, 10);
        check("model_appC1", model_encrypt(PT_C, 10), CT_C1);
        load_store(0, 10);
        run_block(PT_C, CT_C1, 10, "appC1", 1'b1);

        // Random keys and plaintexts
        for (int t = 0; t < 3; t++) begin
            kr = {rand128(), 128'h0};
            pr = rand128();
            expand_key(kr, 4, 10);
            load_store(0, 10);
            run_block(pr, model_encrypt(pr, 10), 10, "rand", 1'b1);
        end

        // 3. Backpressure: result held while downstream stalls, new input ignored
        expand_key({KEY_B, 128'h0}, 4, 10);
        load_store(0, 10);
        pa = rand128();
        ca = model_encrypt(pa, 10);
        run_block(pa, ca, 10, "bp", 1'b0);
        din       = rand128();
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_dout_hold", o_dout, ca);
            check("bp_valid_hold", 128'(o_valid), 128'(1));
            check("bp_din_ready", 128'(o_ready), 128'(0));
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
        check("bp_valid_drop", 128'(o_valid), 128'(0));
        check("bp_idle_ready", 128'(o_ready), 128'(1));

        // 4. Back-to-back blocks with downstream always ready
        pa = rand128();
        pb = rand128();
        ca = model_encrypt(pa, 10);
        cb = model_encrypt(pb, 10);
        din        = pa;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        din = pb;
        n = 0;
        while (!o_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_lat1", 128'(n), 128'(10));
        check("b2b_dout1", o_dout, ca);
        check("b2b_ready_in_done", 128'(o_ready), 128'(1));
        @(posedge clk); #1;
        din_valid = 1'b0;
        check("b2b_accept_valid", 128'(o_valid), 128'(0));
        check("b2b_accept_rk_idx", 128'(o_rk_idx), 128'(1));
        n = 0;
        while (!o_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_gap", 128'(n + 1), 128'(11));
        check("b2b_dout2", o_dout, cb);
        @(posedge clk); #1;
        dout_ready = 1'b0;
        check("b2b_final_valid", 128'(o_valid), 128'(0));

        // 5. Asynchronous reset in the middle of a block
        din       = rand128();
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_rnd", 128'(o_rk_idx), 128'(5));
        rst = 1'b1;
        #1;
        check("rst_mid_dout", o_dout, 128'h0);
        check("rst_mid_valid", 128'(o_valid), 128'(0));
        check("rst_mid_rk_idx", 128'(o_rk_idx), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_block(PT_B, CT_B, 10, "after_rst", 1'b1);

        // 6. NR=14 instance, FIPS-197 App.C.3 and a random AES-256 block
        sel = 1;
        #1;
        expand_key(KEY_C3, 8, 14);
        check("model_appC3", model_encrypt(PT_C, 14), CT_C3);
        load_store(1, 14);
        run_block(PT_C, CT_C3, 14, "appC3", 1'b1);
        kr = {rand128(), rand128()};
        pr = rand128();
        expand_key(kr, 8, 14);
        load_store(1, 14);
        ck = model_encrypt(pr, 14);
        run_block(pr, ck, 14, "rand256", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
